// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN to alternate between requesters on a collision.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   input  logic            if_flush,
   output logic [DW-1:0]   if_rdata,
   output logic            if_valid,
   output logic            if_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wstrb,
   output logic [DW-1:0]   d_rdata,
   output logic            d_valid,
   output logic            d_stall,
   output logic            err,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wstrb,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t          state_reg, state_next;
   logic            owner_reg, owner_next;     // 1 = data requester
   logic [7:0]      cnt_reg, cnt_next;
   logic            flushed_reg, flushed_next;
   logic            rst_q_reg;
   logic            if_elig, pick_d, out_en, done, timed, drop;
   logic            req_c, we_c;
   logic [AW-1:0]   addr_c;
   logic [DW-1:0]   wdata_c;
   logic [DW/8-1:0] wstrb_c;

   assign if_elig = if_req & ~if_flush;

`ifdef MEM_ARB_RR_EN
   logic last_owner_reg;

   // On a collision the requester not served last goes first.
   assign pick_d = d_req & (~if_elig | ~last_owner_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_reg <= 1'b0;
      end else if (state_reg == IDLE && (d_req | if_elig)) begin
         last_owner_reg <= pick_d;
      end
   end
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge clk) begin
      rst_q_reg <= rst;
      if (rst) begin
         state_reg   <= IDLE;
         owner_reg   <= 1'b0;
         cnt_reg     <= '0;
         flushed_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         cnt_reg     <= cnt_next;
         flushed_reg <= flushed_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      owner_next   = owner_reg;
      cnt_next     = cnt_reg;
      flushed_next = flushed_reg;
      req_c        = 1'b0;
      we_c         = 1'b0;
      addr_c       = '0;
      wdata_c      = '0;
      wstrb_c      = '0;
      done         = 1'b0;
      timed        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (d_req | if_elig) begin
               state_next   = REQ;
               owner_next   = pick_d;
               flushed_next = 1'b0;
            end
         end
         REQ: begin
            req_c = 1'b1;
            if (owner_reg) begin
               we_c    = d_we;
               addr_c  = d_addr;
               wdata_c = d_wdata;
               wstrb_c = d_wstrb;
            end else begin
               addr_c  = if_addr;
            end
            if (~owner_reg & if_flush) flushed_next = 1'b1;
            if (m_gnt) begin
               state_next = WAIT;
               cnt_next   = '0;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg + 8'd1;
            if (~owner_reg & if_flush) flushed_next = 1'b1;
            if (m_rvalid) begin
               done       = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               done       = 1'b1;
               timed      = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs stay quiet during reset and the cycle after it.
   assign out_en = ~rst & ~rst_q_reg;
   // A flushed fetch still finishes on the memory side but is not reported.
   assign drop   = ~owner_reg & (flushed_reg | if_flush);

   assign if_valid = out_en & done & ~owner_reg & ~drop;
   assign d_valid  = out_en & done & owner_reg;
   assign err      = out_en & timed & ~drop;
   assign if_rdata = (if_valid & ~timed) ? m_rdata : '0;
   assign d_rdata  = (d_valid & ~timed) ? m_rdata : '0;
   assign if_stall = out_en & if_req & ~if_valid;
   assign d_stall  = out_en & d_req & ~d_valid;

   assign m_req   = out_en & req_c;
   assign m_we    = out_en & we_c;
   assign m_addr  = out_en ? addr_c  : '0;
   assign m_wdata = out_en ? wdata_c : '0;
   assign m_wstrb = out_en ? wstrb_c : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random transactions, each predicted
// from request/grant/response timing; the bench also plays the memory.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_flush, if_valid, if_stall;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_valid, d_stall;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [3:0]    d_wstrb;
   logic          err, m_req, m_we, m_gnt, m_rvalid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [3:0]    m_wstrb;

   int total = 0;
   int bad   = 0;
   int txn_no = 0;
   bit model_last;   // 1 = data requester was served last

   logic        e_ifv, e_dv, e_err, e_mreq, e_mwe;
   logic [31:0] e_ifr, e_dr, e_maddr, e_mwd;
   logic [3:0]  e_mws;
   bit          e_chk_wd, e_quiet;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall), .err(err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      e_ifv = 0; e_dv = 0; e_err = 0; e_mreq = 0; e_mwe = 0;
      e_ifr = 0; e_dr = 0; e_maddr = 0; e_mwd = 0; e_mws = 0;
      e_chk_wd = 0; e_quiet = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input string ph);
      @(negedge clk);
      chk({ph, " if_valid"}, if_valid, e_ifv);
      chk({ph, " d_valid"}, d_valid, e_dv);
      chk({ph, " err"}, err, e_err);
      chk({ph, " m_req"}, m_req, e_mreq);
      chk({ph, " if_stall"}, if_stall, e_quiet ? 1'b0 : (if_req & ~e_ifv));
      chk({ph, " d_stall"}, d_stall, e_quiet ? 1'b0 : (d_req & ~e_dv));
      if (e_quiet) begin
         chk({ph, " if_rdata"}, if_rdata, e_ifr);
         chk({ph, " d_rdata"}, d_rdata, e_dr);
         chk({ph, " m_we"}, m_we, e_mwe);
         chk({ph, " m_addr"}, m_addr, e_maddr);
         chk({ph, " m_wdata"}, m_wdata, e_mwd);
         chk({ph, " m_wstrb"}, m_wstrb, e_mws);
      end else begin
         if (e_ifv) chk({ph, " if_rdata"}, if_rdata, e_ifr);
         if (e_dv | e_err) chk({ph, " d_rdata"}, d_rdata, e_dr);
         if (e_mreq) begin
            chk({ph, " m_addr"}, m_addr, e_maddr);
            chk({ph, " m_we"}, m_we, e_mwe);
            chk({ph, " m_wstrb"}, m_wstrb, e_mws);
         end
         if (e_chk_wd) chk({ph, " m_wdata"}, m_wdata, e_mwd);
      end
   endtask

   // One transaction from the IDLE cycle in which the owner is seen, through gd
   // stalled grant cycles and rdl response cycles (rdl >= TO means no response).
   task automatic run_txn(input bit own_d, input logic [31:0] addr, input bit we,
                          input logic [31:0] wd, input logic [3:0] ws, input int gd,
                          input int rdl, input logic [31:0] rdat, input int flush_at,
                          input bit after_rst);
      bit timed, sup;
      int done_w;
      timed  = (rdl >= TO);
      done_w = timed ? TO - 1 : rdl;
      sup    = !own_d && flush_at >= 0 && flush_at < done_w;
      if (own_d) begin
         d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; d_wstrb = ws;
      end else begin
         if_req = 1; if_addr = addr;
      end
      m_gnt = 0; m_rvalid = after_rst ? 1'b1 : 1'($urandom_range(0, 1)); m_rdata = $urandom;
      clear_exp(); e_quiet = after_rst;
      sample("idle");
      step();
      for (int k = 0; k <= gd; k++) begin
         m_gnt = (k == gd); m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom;
         clear_exp();
         e_mreq = 1; e_maddr = addr; e_mwe = own_d & we;
         e_mws = own_d ? ws : 4'h0; e_mwd = wd; e_chk_wd = own_d;
         sample("req");
         step();
      end
      m_gnt = 0;
      for (int w = 0; w <= done_w; w++) begin
         m_rvalid = (!timed && w == rdl);
         m_rdata  = (w == rdl) ? rdat : $urandom;
         if (flush_at == w) begin
            if_flush = 1;
            if (!own_d) if_req = 0;
         end else begin
            if_flush = 0;
         end
         clear_exp();
         if (w == done_w) begin
            if (own_d) e_dv = 1; else e_ifv = !sup;
            e_err = timed && !sup;
            e_ifr = timed ? 32'h0 : rdat;
            e_dr  = timed ? 32'h0 : rdat;
         end
         sample("wait");
         step();
      end
      m_rvalid = 0; if_flush = 0;
      if (own_d) d_req = 0; else if_req = 0;
      txn_no++;
      $display("txn %0d: %s addr=%h we=%0d gnt_dly=%0d rsp_dly=%0d flush=%0d %s",
               txn_no, own_d ? "D " : "IF", addr, own_d & we, gd, rdl, flush_at,
               sup ? "dropped" : (timed ? "timeout" : "done"));
   endtask

   task automatic txn_single(input bit own_d, input logic [31:0] addr, input bit we,
                             input logic [31:0] wd, input logic [3:0] ws, input int gd,
                             input int rdl, input logic [31:0] rdat, input int flush_at);
      model_last = own_d;
      run_txn(own_d, addr, we, wd, ws, gd, rdl, rdat, flush_at, 1'b0);
   endtask

   // Both requesters raise their request in the same cycle.
   task automatic collide(input logic [31:0] ia, input int igd, input int irdl,
                          input logic [31:0] irdat, input logic [31:0] da, input bit dwe,
                          input logic [31:0] dwd, input logic [3:0] dws, input int dgd,
                          input int drdl, input logic [31:0] drdat);
      bit first_d;
`ifdef MEM_ARB_RR_EN
      first_d = !model_last;
`else
      first_d = 1'b1;
`endif
      if_req = 1; if_addr = ia;
      d_req = 1; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dws;
      model_last = first_d;
      if (first_d) run_txn(1'b1, da, dwe, dwd, dws, dgd, drdl, drdat, -1, 1'b0);
      else         run_txn(1'b0, ia, 1'b0, 32'h0, 4'h0, igd, irdl, irdat, -1, 1'b0);
      model_last = !first_d;
      if (first_d) run_txn(1'b0, ia, 1'b0, 32'h0, 4'h0, igd, irdl, irdat, -1, 1'b0);
      else         run_txn(1'b1, da, dwe, dwd, dws, dgd, drdl, drdat, -1, 1'b0);
   endtask

   int          kind, gd, rdl, gd2, rdl2, fl, dw;
   logic [31:0] ra, ra2, rwd, rrd, rrd2;

   initial begin
      rst = 1; if_req = 0; if_addr = 0; if_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1234_5678;
      model_last = 0;
      step();
      clear_exp(); e_quiet = 1;
      sample("in_rst");
      step();
      rst = 0; m_rvalid = 0;
      clear_exp(); e_quiet = 1;
      sample("post_rst");
      step();

      txn_single(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0050_0093, -1);
      collide(32'h104, 0, 0, 32'h1111_0001, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0);
      txn_single(1'b1, 32'h2004, 1'b0, 32'h0, 4'h0, 0, 1, 32'hCAFE_0001, -1);
      collide(32'h108, 0, 0, 32'h2222_0002, 32'h2008, 1'b0, 32'h0, 4'h0, 0, 0, 32'h3333_0003);

      // Fetch flushed in WAIT, followed directly by a new fetch.
      txn_single(1'b0, 32'h104, 1'b0, 32'h0, 4'h0, 0, 3, 32'hBAD0_0104, 0);
      txn_single(1'b0, 32'h200, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0200, -1);

      // if_req together with if_flush in IDLE must not start a transaction.
      if_req = 1; if_addr = 32'h300; if_flush = 1;
      clear_exp();
      sample("flush_idle");
      step();
      if_req = 0; if_flush = 0;
      clear_exp();
      sample("no_start");
      step();

      // Read timeout, then a late response arriving in IDLE.
      txn_single(1'b1, 32'h4000, 1'b0, 32'h0, 4'h0, 0, TO, 32'h0, -1);
      m_rvalid = 1; m_rdata = 32'h5A5A_5A5A;
      clear_exp();
      sample("late_rsp");
      step();
      m_rvalid = 0;
      clear_exp();
      sample("late_idle");
      step();

      txn_single(1'b1, 32'h4010, 1'b1, 32'h0BAD_F00D, 4'h3, 10, 1, 32'h0, -1);
      txn_single(1'b1, 32'h4014, 1'b0, 32'h0, 4'h0, 0, 2, 32'h7777_8888, 0);

      // Reset while a fetch sits in WAIT.
      if_req = 1; if_addr = 32'h300;
      clear_exp(); sample("pre_idle"); step();
      m_gnt = 1;
      clear_exp(); e_mreq = 1; e_maddr = 32'h300; sample("pre_req"); step();
      m_gnt = 0;
      clear_exp(); sample("pre_wait"); step();
      rst = 1; m_rvalid = 1; m_rdata = 32'hFFFF_0000;
      clear_exp(); e_quiet = 1; sample("mid_rst"); step();
      rst = 0; if_req = 0; model_last = 0;
      run_txn(1'b0, 32'h304, 1'b0, 32'h0, 4'h0, 0, 1, 32'h0000_0304, -1, 1'b1);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         gd = $urandom_range(0, 3); rdl = $urandom_range(0, 5);
         gd2 = $urandom_range(0, 3); rdl2 = $urandom_range(0, 5);
         ra = $urandom & 32'hFFFF_FFFC; ra2 = $urandom & 32'hFFFF_FFFC;
         rwd = $urandom; rrd = $urandom; rrd2 = $urandom;
         dw = (rdl >= TO) ? TO - 1 : rdl;
         fl = -1;
         if (kind == 0 && dw > 0 && $urandom_range(0, 1) == 1) fl = $urandom_range(0, dw - 1);
         case (kind)
            0: txn_single(1'b0, ra, 1'b0, 32'h0, 4'h0, gd, rdl, rrd, fl);
            1: txn_single(1'b1, ra, 1'($urandom_range(0, 1)), rwd, 4'($urandom_range(0, 15)),
                          gd, rdl, rrd, -1);
            default: collide(ra, gd, rdl, rrd, ra2, 1'($urandom_range(0, 1)), rwd,
                             4'($urandom_range(0, 15)), gd2, rdl2, rrd2);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
